// File: rtl/ifetch.sv
// Instruction fetch sequencer: reads opcode plus 0-3 operand bytes, issues the assembled
// instruction to execute, and keeps the program counter in lockstep via ini/lrc pulses.
module ifetch #(
  parameter logic [15:0] RST_VEC  = 16'h8000,
  parameter logic [15:0] ADDR_MAX = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mreq,
  output logic [15:0] ma,
  input  logic [7:0]  di,
  input  logic        mrdy,
  output logic        iv,
  input  logic        iack,
  output logic [7:0]  ir,
  output logic [23:0] op,
  output logic [1:0]  il,
  input  logic        jmp,
  input  logic [15:0] jt,
  output logic        lrc,
  output logic [15:0] ja,
  output logic        ini,
  output logic        oe,
  output logic        flt
);

  localparam logic [15:0] AddrMin = 16'h8000;

  typedef enum logic [1:0] {StFop, StFar, StIss, StFlt} state_e;

  state_e      state_q, state_d;
  logic [15:0] fa_q, fa_d;
  logic [15:0] ja_q, ja_d;
  logic [7:0]  ir_q, ir_d;
  logic [23:0] op_q, op_d;
  logic [1:0]  il_q, il_d;
  logic [1:0]  rc_q, rc_d;
  logic [1:0]  ix_q, ix_d;
  logic        ini_q, ini_d;
  logic        lrc_q, lrc_d;
  logic        mreq_c;

  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    ja_d    = ja_q;
    ir_d    = ir_q;
    op_d    = op_q;
    il_d    = il_q;
    rc_d    = rc_q;
    ix_d    = ix_q;
    ini_d   = 1'b0;
    lrc_d   = 1'b0;
    mreq_c  = 1'b0;
    unique case (state_q)
      StFop: begin
        // Range check gates the request: a bad address never reaches memory.
        if (fa_q < AddrMin || fa_q > ADDR_MAX) begin
          state_d = StFlt;
        end else begin
          mreq_c = 1'b1;
          if (mrdy) begin
            ir_d    = di;
            il_d    = di[7:6];
            rc_d    = di[7:6];
            op_d    = '0;
            ix_d    = '0;
            fa_d    = fa_q + 16'd1;
            ini_d   = 1'b1;
            state_d = (di[7:6] == 2'd0) ? StIss : StFar;
          end
        end
      end
      StFar: begin
        mreq_c = 1'b1;
        if (mrdy) begin
          op_d[{ix_q, 3'b000} +: 8] = di;
          ix_d  = ix_q + 2'd1;
          rc_d  = rc_q - 2'd1;
          fa_d  = fa_q + 16'd1;
          ini_d = 1'b1;
          if (rc_q == 2'd1) state_d = StIss;
        end
      end
      StIss: begin
        if (iack) begin
          if (jmp) begin
            fa_d  = jt;
            ja_d  = jt;
            lrc_d = 1'b1;
          end
          state_d = StFop;
        end
      end
      StFlt: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFop;
      fa_q    <= RST_VEC;
      ja_q    <= RST_VEC;
      ir_q    <= '0;
      op_q    <= '0;
      il_q    <= '0;
      rc_q    <= '0;
      ix_q    <= '0;
      ini_q   <= 1'b0;
      lrc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      ja_q    <= ja_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      il_q    <= il_d;
      rc_q    <= rc_d;
      ix_q    <= ix_d;
      ini_q   <= ini_d;
      lrc_q   <= lrc_d;
    end
  end

  assign mreq = mreq_c;
  assign ma   = fa_q;
  assign iv   = (state_q == StIss);
  assign ir   = ir_q;
  assign op   = op_q;
  assign il   = il_q;
  assign ja   = ja_q;
  assign lrc  = lrc_q;
  assign ini  = ini_q;
  assign oe   = (state_q != StFlt);
  assign flt  = (state_q == StFlt);

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch sequencer that sits on the consuming side of the program counter. It owns the fetch address and issues byte reads to program memory over a req/ready handshake. It assembles variable-length instructions (opcode plus 0–3 operand bytes) and presents them to the execute stage, driving the counter's load/increment controls so the counter stays in lockstep. It also redirects fetch on jumps and traps out-of-range fetch addresses.

## Interface
- `RST_VEC`, 16'h8000, fetch address after reset.
- `ADDR_MAX`, 16'hFFFC, highest legal instruction start address.
- `clk  in  1`  system clock; all state updates on the rising edge.
- `rst  in  1`  asynchronous, active-high reset.
- `mreq  out  1`  memory read request.
- `ma  out  16`  memory read address.
- `di  in  8`  memory read data; valid when `mreq & mrdy`.
- `mrdy  in  1`  memory ready; a byte transfers on each edge where `mreq & mrdy`.
- `iv  out  1`  instruction valid to execute.
- `iack  in  1`  execute accepts the instruction; transfer on edge where `iv & iack`.
- `ir  out  8`  opcode.
- `op  out  24`  operands; byte 1 in [7:0], byte 2 in [15:8], byte 3 in [23:16]; unused bytes are 0.
- `il  out  2`  operand count, equal to `ir[7:6]`.
- `jmp  in  1`  redirect request, sampled only on the `iv & iack` edge.
- `jt  in  16`  jump target, sampled with `jmp`.
- `lrc  out  1`  one-cycle pulse: counter load from `ja`.
- `ja  out  16`  load address for counter.
- `ini  out  1`  one-cycle pulse: counter increment, one per accepted byte.
- `oe  out  1`  counter address-output enable; 1 in all states except FLT.
- `flt  out  1`  fetch-address fault, sticky until reset.

## Operation
- Internal registers: fetch address `fa`[15:0], remaining-operand counter `rc`[1:0], operand index `ix`[1:0].
- States: FOP (fetch opcode), FAR (fetch operand), ISS (issue), FLT (fault).
- Reset (async) values:
  - State FOP, `fa`=RST_VEC, `ja`=RST_VEC.
  - `ir`=0, `op`=0, `il`=0, `rc`=0, `ix`=0.
  - `iv`=0, `lrc`=0, `ini`=0, `flt`=0, `oe`=1.
- `mreq`=1 in FOP and FAR only; `ma`=`fa` at all times.
- FOP:
  - On entry-cycle check: if `fa` < 16'h8000 or `fa` > ADDR_MAX, go to FLT with no request issued (`mreq`=0 that cycle).
  - On a byte transfer: `ir`<=`di`, `il`<=`di[7:6]`, `rc`<=`di[7:6]`, `op`<=0, `ix`<=0, `fa`<=`fa`+1.
  - Next state: ISS if `di[7:6]`==0, else FAR.
- FAR, on a byte transfer:
  - `op` byte[`ix`]<=`di`, `ix`+=1, `rc`-=1, `fa`+=1.
  - Go to ISS when `rc`==1 at the transfer; otherwise stay in FAR.
- ISS: `iv`=1 with `ir`/`op`/`il` held stable. On `iack`:
  - If `jmp`: `fa`<=`jt`, `ja`<=`jt`, pulse `lrc` next cycle.
  - Go to FOP.
- FLT: `flt`=1, `mreq`=0, `iv`=0, `oe`=0; exit only via `rst`.
- Width rules:
  - `fa` increments are 16-bit.
  - A legal start (≤ ADDR_MAX) plus at most 3 operands cannot pass 16'hFFFF, so no wrap inside an instruction.
  - An out-of-range `jt` is accepted and then faults at the next FOP check.

## Timing
- `ini` is registered: high exactly one cycle following each byte transfer.
- `lrc` is registered: high exactly one cycle following an `iack & jmp` edge.
- `ini` and `lrc` are never high together.
- With `mrdy` tied high: opcode-only instruction = 2 cycles (FOP, ISS). A k-operand instruction = k+2 cycles, excluding any `iack` stall.
- `mrdy` low holds the current state, `fa`, and `ma`; no timeout.
- `iack` while `iv`=0 is ignored. `jmp` without `iack` is ignored.
- `rst` asserted mid-instruction: all registers take reset values immediately. Any partially fetched bytes are discarded and `iv` drops without handshake.
- First request after reset release is at RST_VEC on the first clock edge.

## Test plan
- Reset, `mrdy`=1, memory[8000]=8'h05: `mreq`/`ma`=8000 on the first cycle. Next cycle `iv`=1, `ir`=05, `il`=0, `op`=0, with one `ini` pulse. After `iack`, `ma`=8001.
- memory[8000..8003]=C1,AA,BB,CC with `mrdy`=1: `iv` rises 4 cycles after reset release. Expect `ir`=C1, `il`=3, `op`=24'hCCBBAA, four `ini` pulses, and `fa`=8004.
- Same stream with `mrdy` low for 3 cycles during operand 2: `ma` holds 8002 and the state holds. Final `op` is still CCBBAA; `iv` arrives 3 cycles later than before.
- ISS with `iack`=1, `jmp`=1, `jt`=9000: the next cycle has `lrc`=1, `ja`=9000, and no `ini`. The following request is `ma`=9000.
- Jump to `jt`=7FFF, and separately to FFFD: the next cycle enters FLT with `flt`=1, `mreq`=0, `oe`=0. Both remain so until `rst`, after which `ma`=8000.
- Assert `rst` asynchronously during FAR: outputs go to reset values immediately, before the next edge. After release, fetch restarts at 8000 with `op`=0.
